lsu_split: RTL and testbench

- Next-generation load/store unit for the 08_cpu core. Supports the full RV32 LSUOP set, including misaligned accesses.
- A misaligned access that crosses a word boundary is either split into two word accesses or reported as a fault, selected by parameter.
- Sits between the execute stage and the word-addressed, 1-cycle-latency synchronous data memory.
- Adds a valid/ready request handshake and a registered completion pulse.

---
 rtl/lsu_split_pkg.sv | 33 +++
 rtl/lsu_split_align_net.sv | 56 +++++
 rtl/lsu_split.sv | 185 ++++++++++++++++++
 tb/tb_lsu_split.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_split_pkg.sv
// Shared LSU definitions: RV32 load/store op codes, FSM state encodings and
// the misaligned-handling selector.
package lsu_split_pkg;

  localparam int LSUOP_WIDTH = 3;

  localparam logic [LSUOP_WIDTH-1:0] LSUOP_B  = 3'b000;
  localparam logic [LSUOP_WIDTH-1:0] LSUOP_H  = 3'b001;
  localparam logic [LSUOP_WIDTH-1:0] LSUOP_W  = 3'b010;
  localparam logic [LSUOP_WIDTH-1:0] LSUOP_BU = 3'b100;
  localparam logic [LSUOP_WIDTH-1:0] LSUOP_HU = 3'b101;

  typedef enum logic [0:0] {
    LSU_ST_IDLE   = 1'b0,
    LSU_ST_SPLIT2 = 1'b1
  } lsu_state_e;

  localparam bit LSU_MISALIGNED_SPLIT = 1'b1;
  localparam bit LSU_MISALIGNED_FAULT = 1'b0;

  // Unshifted byte enables for an access of the given size.
  function automatic logic [3:0] lsu_base_mask(input logic [LSUOP_WIDTH-1:0] op);
    logic [3:0] mask;
    case (op)
      LSUOP_B, LSUOP_BU: mask = 4'b0001;
      LSUOP_H, LSUOP_HU: mask = 4'b0011;
      LSUOP_W:           mask = 4'b1111;
      default:           mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_split_align_net.sv
// Combinational alignment network: byte-lane placement for stores, crossing and
// illegal-op detection, and load extraction/extension from a 64-bit window.
module lsu_split_align_net
  import lsu_split_pkg::*;
(
  input  logic [LSUOP_WIDTH-1:0] op,
  input  logic [1:0]             off,
  input  logic                   is_store,
  input  logic [31:0]            store_data,
  output logic [7:0]             mask64,
  output logic [63:0]            data64,
  output logic                   crosses,
  output logic                   illegal,
  input  logic [LSUOP_WIDTH-1:0] ld_op,
  input  logic [1:0]             ld_off,
  input  logic [63:0]            ld_window,
  output logic [31:0]            ld_data
);

  logic [31:0] ld_word_s;

  assign mask64    = {4'h0, lsu_base_mask(op)} << off;
  assign data64    = {32'h0, store_data} << {off, 3'b000};
  assign ld_word_s = 32'(ld_window >> {ld_off, 3'b000});

  // Classify the request: word-crossing and illegal op/direction combinations.
  always_comb begin
    crosses = 1'b0;
    illegal = 1'b0;
    case (op)
      LSUOP_B:  crosses = 1'b0;
      LSUOP_H:  crosses = (off == 2'd3);
      LSUOP_W:  crosses = (off != 2'd0);
      LSUOP_BU: illegal = is_store;
      LSUOP_HU: begin
        crosses = (off == 2'd3);
        illegal = is_store;
      end
      default:  illegal = 1'b1;
    endcase
  end

  // Sign- or zero-extend the addressed bytes of the load window.
  always_comb begin
    ld_data = 32'h0;
    case (ld_op)
      LSUOP_B:  ld_data = {{24{ld_word_s[7]}}, ld_word_s[7:0]};
      LSUOP_BU: ld_data = {24'h0, ld_word_s[7:0]};
      LSUOP_H:  ld_data = {{16{ld_word_s[15]}}, ld_word_s[15:0]};
      LSUOP_HU: ld_data = {16'h0, ld_word_s[15:0]};
      LSUOP_W:  ld_data = ld_word_s;
      default:  ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit with valid/ready request handshake, optional two-access split
// of word-crossing accesses, and a registered completion pulse.
module lsu_split
  import lsu_split_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter bit MISALIGNED_MODE = LSU_MISALIGNED_SPLIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_is_store,
  input  logic [LSUOP_WIDTH-1:0] i_op,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [31:0]            i_store_data,
  output logic                   o_done,
  output logic                   o_fault,
  output logic [31:0]            o_load_data,
  output logic                   o_mem_en,
  output logic                   o_mem_is_store,
  output logic [ADDR_W-3:0]      o_mem_addr,
  output logic [31:0]            o_mem_store_data,
  output logic [3:0]             o_mem_store_mask,
  input  logic [31:0]            i_mem_load_data
);

  lsu_state_e state_r;
  lsu_state_e state_s;

  logic                   accept_s;
  logic [1:0]             off_s;
  logic [7:0]             mask64_s;
  logic [63:0]            data64_s;
  logic                   crosses_s;
  logic                   illegal_s;
  logic                   go_fault_s;
  logic                   go_single_s;
  logic                   go_split_s;
  logic                   in_split_s;
  logic [63:0]            window_s;
  logic [31:0]            extract_s;

  logic [LSUOP_WIDTH-1:0] op_r;
  logic [1:0]             off_r;
  logic [ADDR_W-3:0]      word_r;
  logic [3:0]             mask_hi_r;
  logic [31:0]            data_hi_r;
  logic                   store_r;
  logic                   split_r;
  logic [31:0]            lo_buf_r;
  logic                   done_r;
  logic                   fault_r;

  assign o_ready    = (state_r == LSU_ST_IDLE);
  assign accept_s   = i_valid && o_ready;
  assign off_s      = i_addr[1:0];
  assign in_split_s = (state_r == LSU_ST_SPLIT2);

  assign go_fault_s  = accept_s && (illegal_s ||
                       (crosses_s && (MISALIGNED_MODE == LSU_MISALIGNED_FAULT)));
  assign go_split_s  = accept_s && !illegal_s && crosses_s &&
                       (MISALIGNED_MODE == LSU_MISALIGNED_SPLIT);
  assign go_single_s = accept_s && !illegal_s && !crosses_s;

  // A non-split completion only ever sees the single word just read.
  assign window_s = split_r ? {i_mem_load_data, lo_buf_r} : {32'h0, i_mem_load_data};

  lsu_split_align_net u_align (
    .op         (i_op),
    .off        (off_s),
    .is_store   (i_is_store),
    .store_data (i_store_data),
    .mask64     (mask64_s),
    .data64     (data64_s),
    .crosses    (crosses_s),
    .illegal    (illegal_s),
    .ld_op      (op_r),
    .ld_off     (off_r),
    .ld_window  (window_s),
    .ld_data    (extract_s)
  );

  // Next-state logic: only a split-mode crossing access leaves IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LSU_ST_IDLE: begin
        if (go_split_s) begin
          state_s = LSU_ST_SPLIT2;
        end else begin
          state_s = LSU_ST_IDLE;
        end
      end
      LSU_ST_SPLIT2: state_s = LSU_ST_IDLE;
      default:       state_s = LSU_ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LSU_ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory port mux: second half of a split, or the accepted request itself.
  always_comb begin
    o_mem_en         = 1'b0;
    o_mem_is_store   = 1'b0;
    o_mem_addr       = '0;
    o_mem_store_data = 32'h0;
    o_mem_store_mask = 4'h0;
    if (in_split_s) begin
      o_mem_en         = 1'b1;
      o_mem_is_store   = store_r;
      o_mem_addr       = word_r + {{(ADDR_W-3){1'b0}}, 1'b1};
      o_mem_store_data = data_hi_r;
      o_mem_store_mask = mask_hi_r;
    end else if (go_single_s || go_split_s) begin
      o_mem_en         = 1'b1;
      o_mem_is_store   = i_is_store;
      o_mem_addr       = i_addr[ADDR_W-1:2];
      o_mem_store_data = data64_s[31:0];
      o_mem_store_mask = mask64_s[3:0];
    end else begin
      o_mem_en         = 1'b0;
      o_mem_store_mask = 4'h0;
    end
  end

  // Request latches and the low-word buffer for split loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= LSUOP_B;
      off_r     <= 2'd0;
      word_r    <= '0;
      mask_hi_r <= 4'h0;
      data_hi_r <= 32'h0;
      store_r   <= 1'b0;
      lo_buf_r  <= 32'h0;
    end else begin
      if (accept_s) begin
        op_r      <= i_op;
        off_r     <= off_s;
        word_r    <= i_addr[ADDR_W-1:2];
        mask_hi_r <= mask64_s[7:4];
        data_hi_r <= data64_s[63:32];
        store_r   <= i_is_store;
      end
      if (in_split_s) begin
        lo_buf_r <= i_mem_load_data;
      end
    end
  end

  // Completion pulse; reset drops any pending completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      split_r <= 1'b0;
    end else begin
      done_r  <= go_fault_s || go_single_s || in_split_s;
      fault_r <= go_fault_s;
      split_r <= in_split_s;
    end
  end

  assign o_done  = done_r;
  assign o_fault = fault_r;

  // Load result is forced to zero unless a successful load completes.
  always_comb begin
    o_load_data = 32'h0;
    if (done_r && !fault_r && !store_r) begin
      o_load_data = extract_s;
    end else begin
      o_load_data = 32'h0;
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Self-checking bench for lsu_split: one split-mode and one fault-mode instance
// sharing request fields, each with its own 1-cycle synchronous memory model.
module tb_lsu_split;
  import lsu_split_pkg::*;

  typedef struct packed {
    logic        fault;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic valid1, valid0;
  logic is_store;
  logic [LSUOP_WIDTH-1:0] op;
  logic [31:0] addr;
  logic [31:0] sdata;

  logic ready1, done1, fault1, men1, mst1;
  logic [31:0] ld1, mdat1, mrd1;
  logic [29:0] maddr1;
  logic [3:0] mmask1;
  logic ready0, done0, fault0, men0, mst0;
  logic [31:0] ld0, mdat0, mrd0;
  logic [29:0] maddr0;
  logic [3:0] mmask0;

  logic [31:0] mem1 [256];
  logic [31:0] mem0 [256];
  logic        pl1_en, pl0_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  exp_t sb1[$];
  exp_t sb0[$];
  exp_t e;
  int   pass_cnt;
  int   chk_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_split #(.ADDR_W(32), .MISALIGNED_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid1), .o_ready(ready1),
    .i_is_store(is_store), .i_op(op), .i_addr(addr), .i_store_data(sdata),
    .o_done(done1), .o_fault(fault1), .o_load_data(ld1),
    .o_mem_en(men1), .o_mem_is_store(mst1), .o_mem_addr(maddr1),
    .o_mem_store_data(mdat1), .o_mem_store_mask(mmask1), .i_mem_load_data(mrd1)
  );

  lsu_split #(.ADDR_W(32), .MISALIGNED_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid0), .o_ready(ready0),
    .i_is_store(is_store), .i_op(op), .i_addr(addr), .i_store_data(sdata),
    .o_done(done0), .o_fault(fault0), .o_load_data(ld0),
    .o_mem_en(men0), .o_mem_is_store(mst0), .o_mem_addr(maddr0),
    .o_mem_store_data(mdat0), .o_mem_store_mask(mmask0), .i_mem_load_data(mrd0)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory models: preload port, byte-masked writes, registered reads.
  always @(posedge clk) begin
    if (pl1_en) mem1[pl_idx] <= pl_data;
    else if (men1) begin
      if (mst1) mem1[maddr1[7:0]] <= merge(mem1[maddr1[7:0]], mdat1, mmask1);
      else mrd1 <= mem1[maddr1[7:0]];
    end
    if (pl0_en) mem0[pl_idx] <= pl_data;
    else if (men0) begin
      if (mst0) mem0[maddr0[7:0]] <= merge(mem0[maddr0[7:0]], mdat0, mmask0);
      else mrd0 <= mem0[maddr0[7:0]];
    end
  end

  task automatic preload(input logic which1, input logic [7:0] idx, input logic [31:0] d);
    pl1_en = which1; pl0_en = !which1; pl_idx = idx; pl_data = d;
    @(negedge clk);
    pl1_en = 1'b0; pl0_en = 1'b0;
  endtask

  task automatic drive(input logic v1, input logic v0, input logic st,
                       input logic [LSUOP_WIDTH-1:0] o, input logic [31:0] a, input logic [31:0] d);
    valid1 = v1; valid0 = v0; is_store = st; op = o; addr = a; sdata = d;
  endtask

  task automatic idle();
    valid1 = 1'b0; valid0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++; if (ready1 !== 1'b1) $display("FAIL rst_ready act=%b exp=1", ready1); else pass_cnt++;
    chk_cnt++; if (done1 !== 1'b0) $display("FAIL rst_done act=%b exp=0", done1); else pass_cnt++;
    chk_cnt++; if (fault1 !== 1'b0) $display("FAIL rst_fault act=%b exp=0", fault1); else pass_cnt++;
    chk_cnt++; if (ld1 !== 32'h0) $display("FAIL rst_ld act=%h exp=0", ld1); else pass_cnt++;
    chk_cnt++; if (men1 !== 1'b0) $display("FAIL rst_men act=%b exp=0", men1); else pass_cnt++;
    chk_cnt++; if (mmask1 !== 4'h0) $display("FAIL rst_mask act=%b exp=0000", mmask1); else pass_cnt++;
    chk_cnt++; if (done0 !== 1'b0) $display("FAIL rst_done0 act=%b exp=0", done0); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    preload(1'b1, 8'h40, 32'hDEADBEEF);
    preload(1'b1, 8'h41, 32'h01234567);
    drive(1'b1, 1'b0, 1'b0, LSUOP_W, 32'h0000_0100, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'hDEADBEEF});
    #1;
    chk_cnt++; if (men1 !== 1'b1 || mst1 !== 1'b0) $display("FAIL lw_en act=%b/%b exp=1/0", men1, mst1); else pass_cnt++;
    chk_cnt++; if (maddr1 !== 30'h40) $display("FAIL lw_addr act=%h exp=40", maddr1); else pass_cnt++;
    chk_cnt++; if (mmask1 !== 4'b1111) $display("FAIL lw_mask act=%b exp=1111", mmask1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL lw1_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL lw1_data act=%h/%b exp=%h/%b", ld1, fault1, e.data, e.fault);
      else pass_cnt++;
    end
    chk_cnt++; if (ready1 !== 1'b1) $display("FAIL lw_b2b_ready act=%b exp=1", ready1); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, LSUOP_W, 32'h0000_0104, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'h01234567});
    #1;
    chk_cnt++; if (men1 !== 1'b1 || maddr1 !== 30'h41) $display("FAIL lw2_addr act=%b/%h exp=1/41", men1, maddr1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL lw2_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL lw2_data act=%h/%b exp=%h/%b", ld1, fault1, e.data, e.fault);
      else pass_cnt++;
    end
    idle();
    @(negedge clk);
    chk_cnt++; if (done1 !== 1'b0 || ld1 !== 32'h0) $display("FAIL lw_quiet act=%b/%h exp=0/0", done1, ld1); else pass_cnt++;
    sb1.delete();
  endtask

  task automatic test_byte();
    preload(1'b1, 8'h40, 32'h80112233);
    drive(1'b1, 1'b0, 1'b0, LSUOP_B, 32'h103, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'hFFFFFF80});
    #1;
    chk_cnt++; if (mmask1 !== 4'b1000) $display("FAIL lb_mask act=%b exp=1000", mmask1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL lb_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL lb_data act=%h exp=%h", ld1, e.data);
      else pass_cnt++;
    end
    drive(1'b1, 1'b0, 1'b0, LSUOP_BU, 32'h103, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'h00000080});
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL lbu_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL lbu_data act=%h exp=%h", ld1, e.data);
      else pass_cnt++;
    end
    drive(1'b1, 1'b0, 1'b1, LSUOP_B, 32'h102, 32'h0000005A);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b0, data: 32'h0});
    #1;
    chk_cnt++; if (mmask1 !== 4'b0100 || mst1 !== 1'b1) $display("FAIL sb_mask act=%b/%b exp=0100/1", mmask1, mst1); else pass_cnt++;
    chk_cnt++; if (mdat1 !== 32'h005A0000) $display("FAIL sb_data act=%h exp=005a0000", mdat1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL sb_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault) $display("FAIL sb_fault act=%b exp=%b", fault1, e.fault);
      else pass_cnt++;
    end
    idle();
    chk_cnt++; if (mem1[8'h40] !== 32'h805A2233) $display("FAIL sb_mem act=%h exp=805a2233", mem1[8'h40]); else pass_cnt++;
    @(negedge clk);
    sb1.delete();
  endtask

  task automatic test_split_load();
    preload(1'b1, 8'h40, 32'h44332211);
    preload(1'b1, 8'h41, 32'h88776655);
    drive(1'b1, 1'b0, 1'b0, LSUOP_W, 32'h102, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'h66554433});
    #1;
    chk_cnt++; if (men1 !== 1'b1 || maddr1 !== 30'h40 || mmask1 !== 4'b1100) $display("FAIL slw_a act=%b/%h/%b exp=1/40/1100", men1, maddr1, mmask1); else pass_cnt++;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, LSUOP_B, 32'h0, 32'h0);
    #1;
    chk_cnt++; if (ready1 !== 1'b0 || done1 !== 1'b0) $display("FAIL slw_busy act=%b/%b exp=0/0", ready1, done1); else pass_cnt++;
    chk_cnt++; if (men1 !== 1'b1 || maddr1 !== 30'h41 || mmask1 !== 4'b0011) $display("FAIL slw_b act=%b/%h/%b exp=1/41/0011", men1, maddr1, mmask1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL slw_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL slw_data act=%h exp=%h", ld1, e.data);
      else pass_cnt++;
    end
    chk_cnt++; if (ready1 !== 1'b1) $display("FAIL slw_ready act=%b exp=1", ready1); else pass_cnt++;
    idle();
    @(negedge clk);
    chk_cnt++; if (done1 !== 1'b0 || men1 !== 1'b0) $display("FAIL slw_ignored act=%b/%b exp=0/0", done1, men1); else pass_cnt++;
    sb1.delete();
  endtask

  task automatic test_split_store();
    drive(1'b1, 1'b0, 1'b1, LSUOP_H, 32'h007, 32'h0000ABCD);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b0, data: 32'h0});
    #1;
    chk_cnt++; if (maddr1 !== 30'h1 || mmask1 !== 4'b1000 || mdat1 !== 32'hCD000000) $display("FAIL ssh_a act=%h/%b/%h exp=1/1000/cd000000", maddr1, mmask1, mdat1); else pass_cnt++;
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if (men1 !== 1'b1 || maddr1 !== 30'h2 || mmask1 !== 4'b0001 || mdat1 !== 32'h000000AB) $display("FAIL ssh_b act=%b/%h/%b/%h exp=1/2/0001/000000ab", men1, maddr1, mmask1, mdat1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL ssh_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault) $display("FAIL ssh_fault act=%b exp=%b", fault1, e.fault);
      else pass_cnt++;
    end
    e.data = mem1[8'h01];
    chk_cnt++; if (e.data[31:24] !== 8'hCD) $display("FAIL ssh_mem1 act=%h exp=cd", e.data[31:24]); else pass_cnt++;
    e.data = mem1[8'h02];
    chk_cnt++; if (e.data[7:0] !== 8'hAB) $display("FAIL ssh_mem2 act=%h exp=ab", e.data[7:0]); else pass_cnt++;
    preload(1'b1, 8'hFF, 32'hBBAA1111);
    preload(1'b1, 8'h00, 32'h0000DDCC);
    drive(1'b1, 1'b0, 1'b0, LSUOP_W, 32'hFFFF_FFFE, 32'h0);
    sb1.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'hDDCCBBAA});
    #1;
    chk_cnt++; if (maddr1 !== 30'h3FFFFFFF || mmask1 !== 4'b1100) $display("FAIL wrap_a act=%h/%b exp=3fffffff/1100", maddr1, mmask1); else pass_cnt++;
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if (men1 !== 1'b1 || maddr1 !== 30'h0 || mmask1 !== 4'b0011) $display("FAIL wrap_b act=%b/%h/%b exp=1/0/0011", men1, maddr1, mmask1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL wrap_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL wrap_data act=%h exp=%h", ld1, e.data);
      else pass_cnt++;
    end
    @(negedge clk);
    sb1.delete();
  endtask

  task automatic test_fault();
    preload(1'b0, 8'h40, 32'h80010000);
    drive(1'b0, 1'b1, 1'b0, LSUOP_W, 32'h001, 32'h0);
    sb0.push_back('{fault: 1'b1, chk_data: 1'b1, data: 32'h0});
    #1;
    chk_cnt++; if (men0 !== 1'b0) $display("FAIL mis_men act=%b exp=0", men0); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done0 || sb0.size() == 0) $display("FAIL mis_done act=%b exp=1", done0);
    else begin
      e = sb0.pop_front();
      if (fault0 !== e.fault || ld0 !== e.data) $display("FAIL mis_fault act=%b/%h exp=%b/%h", fault0, ld0, e.fault, e.data);
      else pass_cnt++;
    end
    drive(1'b1, 1'b1, 1'b1, LSUOP_HU, 32'h100, 32'h1234);
    sb0.push_back('{fault: 1'b1, chk_data: 1'b1, data: 32'h0});
    sb1.push_back('{fault: 1'b1, chk_data: 1'b1, data: 32'h0});
    #1;
    chk_cnt++; if (men0 !== 1'b0 || men1 !== 1'b0) $display("FAIL hu_men act=%b/%b exp=0/0", men0, men1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done0 || sb0.size() == 0) $display("FAIL hu_done0 act=%b exp=1", done0);
    else begin
      e = sb0.pop_front();
      if (fault0 !== e.fault || ld0 !== e.data) $display("FAIL hu_fault0 act=%b exp=%b", fault0, e.fault);
      else pass_cnt++;
    end
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL hu_done1 act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL hu_fault1 act=%b exp=%b", fault1, e.fault);
      else pass_cnt++;
    end
    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
    sb1.push_back('{fault: 1'b1, chk_data: 1'b1, data: 32'h0});
    #1;
    chk_cnt++; if (men1 !== 1'b0) $display("FAIL ill_men act=%b exp=0", men1); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done1 || sb1.size() == 0) $display("FAIL ill_done act=%b exp=1", done1);
    else begin
      e = sb1.pop_front();
      if (fault1 !== e.fault || ld1 !== e.data) $display("FAIL ill_fault act=%b exp=%b", fault1, e.fault);
      else pass_cnt++;
    end
    drive(1'b0, 1'b1, 1'b0, LSUOP_H, 32'h102, 32'h0);
    sb0.push_back('{fault: 1'b0, chk_data: 1'b1, data: 32'hFFFF8001});
    #1;
    chk_cnt++; if (men0 !== 1'b1 || maddr0 !== 30'h40 || mmask0 !== 4'b1100) $display("FAIL lh0_port act=%b/%h/%b exp=1/40/1100", men0, maddr0, mmask0); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (!done0 || sb0.size() == 0) $display("FAIL lh0_done act=%b exp=1", done0);
    else begin
      e = sb0.pop_front();
      if (fault0 !== e.fault || ld0 !== e.data) $display("FAIL lh0_data act=%h exp=%h", ld0, e.data);
      else pass_cnt++;
    end
    idle();
    @(negedge clk);
    sb0.delete();
    sb1.delete();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, LSUOP_W, 32'h102, 32'h0);
    @(negedge clk);
    idle();
    chk_cnt++; if (ready1 !== 1'b0) $display("FAIL rmid_split act=%b exp=0", ready1); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (men1 !== 1'b0 || ready1 !== 1'b1) $display("FAIL rmid_abort act=%b/%b exp=0/1", men1, ready1); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (done1 !== 1'b0 || men1 !== 1'b0 || ready1 !== 1'b1)
        $display("FAIL rmid_after%0d done/men/ready act=%b/%b/%b exp=0/0/1", i, done1, men1, ready1);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst_n    = 1'b0;
    pl1_en   = 1'b0;
    pl0_en   = 1'b0;
    pl_idx   = 8'h0;
    pl_data  = 32'h0;
    valid1   = 1'b0;
    valid0   = 1'b0;
    is_store = 1'b0;
    op       = LSUOP_W;
    addr     = 32'h0;
    sdata    = 32'h0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_byte();
    test_split_load();
    test_split_store();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
